// File: rtl/axis_flit_serializer_credit.sv
// AXI-Stream to NoC flit serializer: splits each beat into SERIALIZATION_FACTOR flits, LSB slice first,
// and issues them under credit-based flow control against the downstream router input buffer.
module axis_flit_serializer_credit #(
  parameter int TDATA_WIDTH          = 128,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int DEST_WIDTH           = 6,
  parameter int FLIT_BUFFER_DEPTH    = 2,
  parameter int PACKET_MODE          = 0,
  localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int CW                  = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic [TDATA_WIDTH-1:0] axis_tdata,
  input  logic                   axis_tlast,
  input  logic [DEST_WIDTH-1:0]  axis_tdest,
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  output logic [CW-1:0]          credit_count,
  output logic                   credit_err
);

  localparam int IW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(SERIALIZATION_FACTOR - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);
  localparam logic PM_EN = (PACKET_MODE != 0);

  logic                   hold_valid_q, hold_valid_d;
  logic [TDATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [DEST_WIDTH-1:0]  hold_dest_q, hold_dest_d;
  logic                   hold_last_q, hold_last_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          credit_q, credit_d;
  logic                   err_q, err_d;
  logic                   send_q, send_d;
  logic [FLIT_WIDTH-1:0]  data_q, data_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;
  logic                   tail_q, tail_d;

  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] hold_flits;
  logic issue, issue_last, accept;

  assign hold_flits  = hold_data_q;
  assign issue       = hold_valid_q && (credit_q != '0);
  assign issue_last  = issue && (idx_q == IDX_LAST);
  assign axis_tready = !hold_valid_q || issue_last;
  assign accept      = axis_tvalid && axis_tready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_dest_d  = hold_dest_q;
    hold_last_d  = hold_last_q;
    idx_d        = idx_q;
    credit_d     = credit_q;
    err_d        = err_q;
    send_d       = 1'b0;
    data_d       = data_q;
    dest_d       = dest_q;
    tail_d       = tail_q;

    if (issue) begin
      send_d = 1'b1;
      data_d = hold_flits[idx_q];
      dest_d = hold_dest_q;
      tail_d = issue_last && (PM_EN || hold_last_q);
      idx_d  = issue_last ? '0 : idx_q + IW'(1);
    end

    // A beat arriving on the wrap edge reloads the hold register in place of clearing it.
    if (issue_last) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = axis_tdata;
      hold_dest_d  = axis_tdest;
      hold_last_d  = axis_tlast;
    end

    unique case ({issue, credit_in})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CREDIT_MAX) err_d = 1'b1;
        else                        credit_d = credit_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_dest_q  <= '0;
      hold_last_q  <= 1'b0;
      idx_q        <= '0;
      credit_q     <= CREDIT_MAX;
      err_q        <= 1'b0;
      send_q       <= 1'b0;
      data_q       <= '0;
      dest_q       <= '0;
      tail_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_dest_q  <= hold_dest_d;
      hold_last_q  <= hold_last_d;
      idx_q        <= idx_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
      send_q       <= send_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      tail_q       <= tail_d;
    end
  end

  assign send_out     = send_q;
  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign credit_count = credit_q;
  assign credit_err   = err_q;

endmodule

// File: tb/tb_axis_flit_serializer_credit.sv
// Bench for axis_flit_serializer_credit: three configurations (SF=4, SF=1, SF=2 packet mode) run against
// a transaction-level reference model, with directed scenarios followed by randomized traffic.
module tb_axis_flit_serializer_credit;

  localparam int NI = 3;
  localparam int SFV [NI] = '{4, 1, 2};
  localparam int DEPTH = 2;

  logic clk_noc = 1'b0;
  logic rst_n;
  always #5 clk_noc = ~clk_noc;

  logic         d_tvalid [NI];
  logic         d_tlast  [NI];
  logic         d_credit [NI];
  logic [127:0] d_tdata  [NI];
  logic [5:0]   d_tdest  [NI];

  logic         o_tready [NI];
  logic         o_send   [NI];
  logic         o_tail   [NI];
  logic         o_err    [NI];
  logic [1:0]   o_cnt    [NI];
  logic [5:0]   o_dest   [NI];
  logic [31:0]  o_data0;
  logic [127:0] o_data1;
  logic [63:0]  o_data2;

  axis_flit_serializer_credit #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(4), .DEST_WIDTH(6),
                                .FLIT_BUFFER_DEPTH(DEPTH), .PACKET_MODE(0)) u0 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_tvalid(d_tvalid[0]), .axis_tready(o_tready[0]),
    .axis_tdata(d_tdata[0]), .axis_tlast(d_tlast[0]), .axis_tdest(d_tdest[0]), .data_out(o_data0),
    .dest_out(o_dest[0]), .is_tail_out(o_tail[0]), .send_out(o_send[0]), .credit_in(d_credit[0]),
    .credit_count(o_cnt[0]), .credit_err(o_err[0]));

  axis_flit_serializer_credit #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(1), .DEST_WIDTH(6),
                                .FLIT_BUFFER_DEPTH(DEPTH), .PACKET_MODE(0)) u1 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_tvalid(d_tvalid[1]), .axis_tready(o_tready[1]),
    .axis_tdata(d_tdata[1]), .axis_tlast(d_tlast[1]), .axis_tdest(d_tdest[1]), .data_out(o_data1),
    .dest_out(o_dest[1]), .is_tail_out(o_tail[1]), .send_out(o_send[1]), .credit_in(d_credit[1]),
    .credit_count(o_cnt[1]), .credit_err(o_err[1]));

  axis_flit_serializer_credit #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(2), .DEST_WIDTH(6),
                                .FLIT_BUFFER_DEPTH(DEPTH), .PACKET_MODE(1)) u2 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_tvalid(d_tvalid[2]), .axis_tready(o_tready[2]),
    .axis_tdata(d_tdata[2]), .axis_tlast(d_tlast[2]), .axis_tdest(d_tdest[2]), .data_out(o_data2),
    .dest_out(o_dest[2]), .is_tail_out(o_tail[2]), .send_out(o_send[2]), .credit_in(d_credit[2]),
    .credit_count(o_cnt[2]), .credit_err(o_err[2]));

  // Reference model: the beat being serialized, the next flit number, credits and expected outputs.
  bit           m_hv   [NI];
  logic [127:0] m_data [NI];
  logic [5:0]   m_dest [NI];
  bit           m_last [NI];
  int           m_idx  [NI];
  int           m_cnt  [NI];
  bit           m_err  [NI];
  bit           m_acc  [NI];
  bit           e_send [NI];
  bit           e_tail [NI];
  logic [127:0] e_data [NI];
  logic [5:0]   e_dest [NI];
  bit           h1 [NI], h2 [NI];
  int           tv_mode [NI], cr_mode [NI];
  int           n_send [NI], n_tail [NI];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] odata(input int k);
    case (k)
      0:       return {96'b0, o_data0};
      1:       return o_data1;
      default: return {64'b0, o_data2};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_hv[k] = 0; m_idx[k] = 0; m_cnt[k] = DEPTH; m_err[k] = 0; m_acc[k] = 0;
      e_send[k] = 0; e_tail[k] = 0; e_data[k] = '0; e_dest[k] = '0;
      h1[k] = 0; h2[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_noc);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.rst.send", k), o_send[k], 0);
      chk($sformatf("u%0d.rst.data", k), odata(k), 0);
      chk($sformatf("u%0d.rst.tready", k), o_tready[k], 1);
      chk($sformatf("u%0d.rst.credit", k), o_cnt[k], DEPTH);
      chk($sformatf("u%0d.rst.err", k), o_err[k], 0);
    end
    @(negedge clk_noc);
    rst_n = 1'b1;
  endtask

  // One clock: check pre-edge status, pick stimulus, advance the model, then check registered outputs.
  task automatic step();
    for (int k = 0; k < NI; k++) begin
      bit iss, il, tr;
      int fw;
      logic [127:0] mask;
      iss = m_hv[k] && (m_cnt[k] != 0);
      il  = iss && (m_idx[k] == SFV[k] - 1);
      tr  = !m_hv[k] || il;
      chk($sformatf("u%0d.tready", k), o_tready[k], tr);
      chk($sformatf("u%0d.credit", k), o_cnt[k], m_cnt[k]);
      chk($sformatf("u%0d.err", k), o_err[k], m_err[k]);

      if (tv_mode[k] != 0) begin
        d_tvalid[k] = (tv_mode[k] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        d_tdata[k]  = {$urandom, $urandom, $urandom, $urandom};
        d_tdest[k]  = 6'($urandom);
        d_tlast[k]  = 1'($urandom_range(0, 1));
      end
      case (cr_mode[k])
        1: d_credit[k] = h2[k];
        2: d_credit[k] = iss;
        3: d_credit[k] = ((m_cnt[k] < DEPTH) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 49) == 0);
        default: ;
      endcase

      fw   = 128 / SFV[k];
      mask = (fw == 128) ? {128{1'b1}} : ((128'd1 << fw) - 128'd1);
      e_send[k] = iss;
      if (iss) begin
        e_data[k] = (m_data[k] >> (m_idx[k] * fw)) & mask;
        e_dest[k] = m_dest[k];
        e_tail[k] = il && ((k == 2) || m_last[k]);
      end
      if (iss && !d_credit[k]) m_cnt[k]--;
      else if (!iss && d_credit[k]) begin
        if (m_cnt[k] == DEPTH) m_err[k] = 1;
        else m_cnt[k]++;
      end
      if (iss) begin
        m_idx[k]++;
        if (m_idx[k] == SFV[k]) begin m_idx[k] = 0; m_hv[k] = 0; end
      end
      m_acc[k] = d_tvalid[k] && tr;
      if (m_acc[k]) begin
        m_hv[k] = 1; m_data[k] = d_tdata[k]; m_dest[k] = d_tdest[k]; m_last[k] = d_tlast[k];
      end
    end
    @(posedge clk_noc);
    @(negedge clk_noc);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.send", k), o_send[k], e_send[k]);
      chk($sformatf("u%0d.data", k), odata(k), e_data[k]);
      chk($sformatf("u%0d.dest", k), o_dest[k], e_dest[k]);
      chk($sformatf("u%0d.tail", k), o_tail[k], e_tail[k]);
      if (o_send[k]) n_send[k]++;
      if (o_send[k] && o_tail[k]) n_tail[k]++;
      h2[k] = h1[k];
      h1[k] = e_send[k];
    end
  endtask

  initial begin
    int nb;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      d_tvalid[k] = 0; d_tlast[k] = 0; d_credit[k] = 0; d_tdata[k] = '0; d_tdest[k] = '0;
      tv_mode[k] = 0; cr_mode[k] = 0; n_send[k] = 0; n_tail[k] = 0;
    end
    model_reset();
    do_reset();

    // SF=4 single beat, credits echoed two cycles after each flit.
    cr_mode[0] = 1;
    d_tvalid[0] = 1; d_tlast[0] = 1; d_tdest[0] = 6'h15;
    d_tdata[0] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    n_send[0] = 0; n_tail[0] = 0;
    step();
    d_tvalid[0] = 0;
    d_tdata[0] = {4{32'hdeadbeef}};
    repeat (20) step();
    chk("sf4.flits", n_send[0], 4);
    chk("sf4.tails", n_tail[0], 1);

    // SF=1, no credits returned: two flits then stall; one credit releases exactly one more.
    tv_mode[1] = 1; cr_mode[1] = 0; d_credit[1] = 0; n_send[1] = 0;
    repeat (8) step();
    chk("sf1.stall_flits", n_send[1], 2);
    chk("sf1.stall_tready", o_tready[1], 0);
    chk("sf1.stall_credit", o_cnt[1], 0);
    d_credit[1] = 1;
    step();
    d_credit[1] = 0;
    repeat (6) step();
    chk("sf1.one_more", n_send[1], 3);
    tv_mode[1] = 0; d_tvalid[1] = 0;

    // SF=1 back-to-back beats with credit returned alongside each flit.
    do_reset();
    tv_mode[1] = 1; cr_mode[1] = 2; n_send[1] = 0;
    repeat (8) step();
    tv_mode[1] = 0; d_tvalid[1] = 0;
    repeat (4) step();
    chk("sf1.b2b_flits", n_send[1], 8);
    chk("sf1.b2b_credit", o_cnt[1], DEPTH);

    // Packet mode SF=2: two non-last beats, tail on every beat's second flit.
    cr_mode[2] = 1; n_send[2] = 0; n_tail[2] = 0; nb = 0;
    d_tvalid[2] = 1; d_tlast[2] = 0; d_tdata[2] = {$urandom, $urandom, $urandom, $urandom};
    d_tdest[2] = 6'h2a;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      step();
      if (m_acc[2]) begin
        nb++;
        d_tdata[2] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    d_tvalid[2] = 0;
    repeat (10) step();
    chk("pm.beats", nb, 2);
    chk("pm.flits", n_send[2], 4);
    chk("pm.tails", n_tail[2], 2);

    // Credit overflow is sticky until reset; reset mid-beat drops the rest of the beat.
    cr_mode[0] = 0; d_credit[0] = 1;
    step();
    d_credit[0] = 0;
    repeat (3) step();
    chk("ovf.err", o_err[0], 1);
    chk("ovf.credit", o_cnt[0], DEPTH);
    cr_mode[0] = 1;
    d_tvalid[0] = 1; d_tlast[0] = 1; d_tdata[0] = {$urandom, $urandom, $urandom, $urandom};
    step();
    d_tvalid[0] = 0;
    repeat (2) step();
    do_reset();
    n_send[0] = 0;
    repeat (10) step();
    chk("rst_mid.flits", n_send[0], 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < NI; k++) begin tv_mode[k] = 2; cr_mode[k] = 3; end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
